// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-unit BIST sequencer:
// FSM states, expected truth table and result bit positions.
`default_nettype none

package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int RES_W = 7;

    // Bit positions inside the gate unit result word.
    localparam int RES_NAND  = 0;
    localparam int RES_NOT_A = 1;
    localparam int RES_AND   = 2;
    localparam int RES_OR    = 3;
    localparam int RES_NOR   = 4;
    localparam int RES_XOR   = 5;
    localparam int RES_XNOR  = 6;

    // Indexed by the applied vector {a,b}.
    localparam logic [RES_W-1:0] EXP_TABLE [0:3] = '{7'h53, 7'h2B, 7'h29, 7'h4C};

endpackage : gate_bist_pkg

`default_nettype wire

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: walks {a,b} through 00..11, waits SETTLE cycles per vector,
// compares the seven gate-unit outputs against EXP_TABLE and records the results.
`default_nettype none

module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [RES_W-1:0] res,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [RES_W-1:0] fail_mask,
    output logic             fail_seen,
    output logic [1:0]       first_fail
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [RES_W-1:0] mask_q, mask_d;
    logic             seen_q, seen_d;
    logic [1:0]       ff_q, ff_d;
    logic             pass_q, pass_d;
    logic [RES_W-1:0] mismatch;

    assign mismatch = res ^ EXP_TABLE[vec_q];

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        seen_d  = seen_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = '0;
                    seen_d  = 1'b0;
                    ff_d    = 2'd0;
                    pass_d  = 1'b0;
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                mask_d = mask_q | mismatch;
                // Only the first failing vector is remembered.
                if ((mismatch != '0) && !seen_q) begin
                    seen_d = 1'b1;
                    ff_d   = vec_q;
                end
                if (vec_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = 4'd0;
                    state_d = APPLY;
                end
            end
            DONE: begin
                pass_d  = (mask_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            mask_q  <= '0;
            seen_q  <= 1'b0;
            ff_q    <= 2'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            seen_q  <= seen_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    // The vector register is the stimulus itself, so a/b stay registered.
    assign a          = vec_q[1];
    assign b          = vec_q[0];
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign fail_mask  = mask_q;
    assign fail_seen  = seen_q;
    assign first_fail = ff_q;

endmodule : gate_bist_ctrl

`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench: two sequencers (SETTLE=1 and SETTLE=3) each driving a
// fault-injectable gate-unit model, checked every cycle against a run-level model.
`default_nettype none

module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] f0 = 7'h00;
    logic [6:0] inv [4];

    logic [6:0] res_w [2];
    logic       a_o [2];
    logic       b_o [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic       pass_o [2];
    logic [6:0] mask_o [2];
    logic       seen_o [2];
    logic [1:0] ff_o [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] good(input logic [1:0] v);
        logic x, y;
        x = v[1];
        y = v[0];
        return {~(x ^ y), x ^ y, ~(x | y), x | y, x & y, ~x, ~(x & y)};
    endfunction

    always_comb res_w[0] = (good({a_o[0], b_o[0]}) ^ inv[{a_o[0], b_o[0]}]) & ~f0;
    always_comb res_w[1] = (good({a_o[1], b_o[1]}) ^ inv[{a_o[1], b_o[1]}]) & ~f0;

    gate_bist_ctrl #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .res(res_w[0]),
        .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .fail_mask(mask_o[0]), .fail_seen(seen_o[0]), .first_fail(ff_o[0])
    );

    gate_bist_ctrl #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .res(res_w[1]),
        .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .fail_mask(mask_o[1]), .fail_seen(seen_o[1]), .first_fail(ff_o[1])
    );

    // ---------------- run-level reference model ----------------
    bit         m_busy [2];
    bit         m_run  [2];
    bit         m_pass [2];
    int         m_p    [2];
    logic [6:0] m_err  [2][4];

    function automatic int st(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [6:0] err_now(input int v);
        logic [1:0] vb;
        vb = 2'(v);
        return ((good(vb) ^ inv[vb]) & ~f0) ^ good(vb);
    endfunction

    function automatic logic [6:0] full_mask(input int i);
        logic [6:0] m;
        m = 7'h00;
        for (int v = 0; v < 4; v++) m = m | m_err[i][v];
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_busy[i] <= 1'b0;
                m_run[i]  <= 1'b0;
                m_pass[i] <= 1'b0;
                m_p[i]    <= 0;
            end else if (!m_busy[i]) begin
                if (start) begin
                    m_busy[i] <= 1'b1;
                    m_run[i]  <= 1'b1;
                    m_pass[i] <= 1'b0;
                    m_p[i]    <= 0;
                    for (int v = 0; v < 4; v++) m_err[i][v] <= err_now(v);
                end
            end else if (m_p[i] == 4 * (st(i) + 1)) begin
                m_busy[i] <= 1'b0;
                m_pass[i] <= (full_mask(i) == 7'h00);
            end else begin
                m_p[i] <= m_p[i] + 1;
            end
        end
    end

    // Packed {a,b,busy,done,pass,mask,seen,first_fail}
    function automatic logic [14:0] exp_vec(input int i);
        int         s, last, pe, vv;
        logic [6:0] m;
        logic       sn;
        logic [1:0] ff;
        s    = st(i);
        last = 4 * (s + 1);
        pe   = m_busy[i] ? m_p[i] : (m_run[i] ? last + 1 : 0);
        m    = 7'h00;
        sn   = 1'b0;
        ff   = 2'd0;
        for (int v = 0; v < 4; v++) begin
            if ((v * (s + 1) + s) < pe) begin
                m = m | m_err[i][v];
                if (m_err[i][v] != 7'h00 && !sn) begin
                    sn = 1'b1;
                    ff = 2'(v);
                end
            end
        end
        vv = m_busy[i] ? ((m_p[i] / (s + 1)) > 3 ? 3 : m_p[i] / (s + 1)) : (m_run[i] ? 3 : 0);
        return {vv[1:0], m_busy[i], (m_busy[i] && m_p[i] == last), m_pass[i], m, sn, ff};
    endfunction

    function automatic logic [14:0] got_vec(input int i);
        return {a_o[i], b_o[i], busy_o[i], done_o[i], pass_o[i], mask_o[i], seen_o[i], ff_o[i]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", nm, got, expv, $time);
        end
    endtask

    task automatic chk_results(input string nm, input logic [6:0] em, input logic [1:0] eff,
                               input logic es, input logic ep);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_mask_d%0d", nm, i), 32'(mask_o[i]), 32'(em));
            chk($sformatf("%s_seen_d%0d", nm, i), 32'(seen_o[i]), 32'(es));
            if (es) chk($sformatf("%s_ff_d%0d", nm, i), 32'(ff_o[i]), 32'(eff));
            chk($sformatf("%s_pass_d%0d", nm, i), 32'(pass_o[i]), 32'(ep));
        end
    endtask

    // start is driven just after edge 0, so the DUT samples it at edge 1.
    task automatic run(input string nm, input logic [6:0] em, input logic [1:0] eff,
                       input logic es, input logic ep, input bit restart);
        int k, d1, d3;
        @(posedge clk); #1;
        start = 1'b1;
        k = 0; d1 = 0; d3 = 0;
        while ((d1 == 0 || d3 == 0) && k < 60) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) start = 1'b0;
            if (restart && k == 4) start = 1'b1;
            if (restart && k == 5) start = 1'b0;
            if (k == 1 || k == 3 || k == 5 || k == 7)
                chk($sformatf("%s_ab_k%0d", nm, k), 32'({a_o[0], b_o[0]}), 32'((k - 1) / 2));
            if (done_o[0] && d1 == 0) d1 = k;
            if (done_o[1] && d3 == 0) d3 = k;
        end
        chk({nm, "_done_edge_s1"}, 32'(d1), 32'd9);
        chk({nm, "_done_edge_s3"}, 32'(d3), 32'd17);
        repeat (2) @(posedge clk);
        #1;
        chk_results(nm, em, eff, es, ep);
    endtask

    initial begin
        for (int v = 0; v < 4; v++) inv[v] = 7'h00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < 2; i++)
                    chk($sformatf("cycle_d%0d", i), 32'(got_vec(i)), 32'(exp_vec(i)));
            end
        join_none

        chk_results("reset", 7'h00, 2'd0, 1'b0, 1'b0);
        chk("reset_ab_busy", 32'({a_o[0], b_o[0], busy_o[0], done_o[0]}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run("healthy", 7'h00, 2'd0, 1'b0, 1'b1, 1'b0);

        f0 = 7'(1 << RES_XOR);
        run("xor_stuck0", 7'h20, 2'b01, 1'b1, 1'b0, 1'b0);
        f0 = 7'h00;

        inv[3] = 7'(1 << RES_NAND);
        run("nand_at_11", 7'h01, 2'b11, 1'b1, 1'b0, 1'b1);
        inv[3] = 7'h00;
        run("rerun_clean", 7'h00, 2'd0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a run.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("midrst_outs_d%0d", i), 32'(got_vec(i)), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_no_done", 32'({done_o[0], done_o[1]}), 32'd0);
        end
        rst_n = 1'b1;
        run("after_reset", 7'h00, 2'd0, 1'b0, 1'b1, 1'b0);

        // Randomized faults and start/reset traffic.
        for (int it = 0; it < 6; it++) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            f0 = 7'($urandom & $urandom & $urandom);
            for (int v = 0; v < 4; v++)
                inv[v] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom & $urandom);
            @(posedge clk); #1;
            rst_n = 1'b1;
            for (int c = 0; c < 150; c++) begin
                @(posedge clk); #1;
                start = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 79) == 0) begin
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                end
            end
        end
        start = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gate_bist_ctrl

`default_nettype wire
